// File: rtl/set_pkg.sv
// set_pkg: shared widths, FSM state encoding and SET mode constants for set_job_sched.
package set_pkg;

    localparam int CENTRAL_W = 24;
    localparam int RADIUS_W  = 12;
    localparam int MODE_W    = 2;
    localparam int CAND_W    = 8;

    localparam logic [MODE_W-1:0] MODE_A            = 2'd0;
    localparam logic [MODE_W-1:0] MODE_AND          = 2'd1;
    localparam logic [MODE_W-1:0] MODE_XOR          = 2'd2;
    localparam logic [MODE_W-1:0] MODE_TWO_OF_THREE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DRAIN,
        ST_RESP
    } state_t;

endpackage

// File: rtl/set_job_sched_if.sv
// set_job_sched_if: request, engine and response signals around the SET job scheduler.
interface set_job_sched_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    import set_pkg::*;

    logic [NREQ-1:0]           req_valid;
    logic [NREQ-1:0]           req_ready;
    logic [CENTRAL_W*NREQ-1:0] req_central;
    logic [RADIUS_W*NREQ-1:0]  req_radius;
    logic [MODE_W*NREQ-1:0]    req_mode;
    logic                      eng_en;
    logic [CENTRAL_W-1:0]      eng_central;
    logic [RADIUS_W-1:0]       eng_radius;
    logic [MODE_W-1:0]         eng_mode;
    logic                      eng_busy;
    logic                      eng_valid;
    logic [CAND_W-1:0]         eng_candidate;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [IDW-1:0]            rsp_id;
    logic [CAND_W-1:0]         rsp_candidate;
    logic                      rsp_err;
    logic [15:0]               jobs_done;

    modport slave (
        input  req_valid, req_central, req_radius, req_mode,
        input  eng_busy, eng_valid, eng_candidate, rsp_ready,
        output req_ready, eng_en, eng_central, eng_radius, eng_mode,
        output rsp_valid, rsp_id, rsp_candidate, rsp_err, jobs_done
    );

    modport master (
        output req_valid, req_central, req_radius, req_mode,
        output eng_busy, eng_valid, eng_candidate, rsp_ready,
        input  req_ready, eng_en, eng_central, eng_radius, eng_mode,
        input  rsp_valid, rsp_id, rsp_candidate, rsp_err, jobs_done
    );

endinterface

// File: rtl/set_rr_arb.sv
// set_rr_arb: combinational round-robin picker; first valid request at or above ptr, with wrap.
module set_rr_arb #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx
);

    logic [IDW-1:0] j;

    // Scan from the farthest offset down so the closest request to ptr wins last.
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = IDW'((int'(ptr) + i) % NREQ);
            if (req_valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/set_job_sched.sv
// set_job_sched: round-robin front end sharing one SET candidate engine between NREQ requesters.
// Define SET_SCHED_TIMEOUT_EN to add a run watchdog that reports rsp_err on expiry.
module set_job_sched
    import set_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int IDW         = 2,
    parameter int TIMEOUT_CYC = 1023
) (
    input logic            clk,
    input logic            rst,
    set_job_sched_if.slave bus
);

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  gidx;
    logic [NREQ-1:0] grant;
    logic            take;

`ifdef SET_SCHED_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 10) ? $clog2(TIMEOUT_CYC + 1) : 10;
    logic [CNT_W-1:0] cnt;
`else
    assign bus.rsp_err = 1'b0;
`endif

    set_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_valid(bus.req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .idx      (gidx)
    );

    assign bus.req_ready = (state == ST_IDLE) ? grant : '0;
    assign take          = |(bus.req_valid & bus.req_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_IDLE;
            ptr               <= '0;
            bus.eng_en        <= 1'b0;
            bus.eng_central   <= '0;
            bus.eng_radius    <= '0;
            bus.eng_mode      <= '0;
            bus.rsp_valid     <= 1'b0;
            bus.rsp_id        <= '0;
            bus.rsp_candidate <= '0;
            bus.jobs_done     <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
            bus.rsp_err       <= 1'b0;
            cnt               <= '0;
`endif
        end else begin
            bus.eng_en <= 1'b0;
            case (state)
                ST_IDLE: if (take) begin
                    bus.eng_central <= bus.req_central[int'(gidx)*CENTRAL_W +: CENTRAL_W];
                    bus.eng_radius  <= bus.req_radius[int'(gidx)*RADIUS_W +: RADIUS_W];
                    bus.eng_mode    <= bus.req_mode[int'(gidx)*MODE_W +: MODE_W];
                    bus.rsp_id      <= gidx;
                    bus.eng_en      <= 1'b1;
                    state           <= ST_LAUNCH;
`ifdef SET_SCHED_TIMEOUT_EN
                    bus.rsp_err     <= 1'b0;
`endif
                end
                ST_LAUNCH: begin
                    state <= ST_RUN;
`ifdef SET_SCHED_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                ST_RUN: if (bus.eng_valid) begin
                    bus.rsp_candidate <= bus.eng_candidate;
                    state             <= ST_DRAIN;
                end
`ifdef SET_SCHED_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT_CYC)) begin
                    bus.rsp_candidate <= '0;
                    bus.rsp_err       <= 1'b1;
                    bus.rsp_valid     <= 1'b1;
                    state             <= ST_RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
`endif
                // Holding here until busy drops keeps the next eng_en off a running engine.
                ST_DRAIN: if (!bus.eng_busy) begin
                    bus.rsp_valid <= 1'b1;
                    state         <= ST_RESP;
                end
                ST_RESP: if (bus.rsp_ready) begin
                    bus.rsp_valid <= 1'b0;
                    bus.jobs_done <= bus.jobs_done + 16'd1;
                    ptr           <= (bus.rsp_id == IDW'(NREQ - 1)) ? '0 : bus.rsp_id + IDW'(1);
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_job_sched.sv
// tb_set_job_sched: table-driven scheduler bench with an engine model and a response scoreboard.
// Build with SET_SCHED_TIMEOUT_EN to also exercise the watchdog path.
module tb_set_job_sched;
    import set_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int TO   = 20;
`ifdef SET_SCHED_TIMEOUT_EN
    localparam int LONG = 15;
`else
    localparam int LONG = 300;
`endif

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     cand;
        logic           err;
        logic [37:0]    ops;
    } exp_t;

    typedef struct {
        logic [3:0] mask;
        int         lat;
        int         extra;
        int         exp_id;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int nvec = 0, nerr = 0;
    int lat = 3, extra = 0, k = 0, cyc = 0, grants = 0, jobs = 0, ens = 0;
    int last_id = 0, gid = 0, t_ev = 0, t_rv = 0, t_en = 0;
    int n, e0, g0, bad;
    bit hang = 0, run = 0, prev_rv = 0;
    logic [7:0]     last_cand = '0;
    logic [37:0]    ops;
    logic [IDW-1:0] sid;
    logic [7:0]     scand;
    logic           serr;
    exp_t q[$];
    exp_t e;
    vec_t vecs[12];
    int dx[3]   = '{3, 0, 1};
    int dexp[3] = '{4, 2, 2};

    always #5 clk = ~clk;

    set_job_sched_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    set_job_sched #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [7:0] f(logic [23:0] c, logic [11:0] r, logic [1:0] m);
        return c[7:0] + c[23:16] + r[7:0] + 8'(m);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_job(input int r, input logic [23:0] c, input logic [11:0] rad, input logic [1:0] m);
        bus.req_central[r*24 +: 24] = c;
        bus.req_radius[r*12 +: 12]  = rad;
        bus.req_mode[r*2 +: 2]      = m;
    endtask

    task automatic wait_grant(input string nm, output int cnt);
        int g;
        int i;
        g = grants;
        for (i = 0; i < 1000 && grants == g; i++) begin
            @(negedge clk);
            #1;
        end
        cnt = i;
        chk(nm, grants, g + 1);
    endtask

    task automatic wait_done(input string nm);
        int j;
        j = jobs;
        for (int i = 0; i < 1000 && jobs == j; i++) begin
            @(negedge clk);
            #1;
        end
        chk(nm, jobs, j + 1);
    endtask

    task automatic reset_checks(input string p);
        chk({p, "_req_ready"}, bus.req_ready, 0);
        chk({p, "_eng_en"}, bus.eng_en, 0);
        chk({p, "_eng_central"}, bus.eng_central, 0);
        chk({p, "_eng_radius"}, bus.eng_radius, 0);
        chk({p, "_eng_mode"}, bus.eng_mode, 0);
        chk({p, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({p, "_rsp_id"}, bus.rsp_id, 0);
        chk({p, "_rsp_candidate"}, bus.rsp_candidate, 0);
        chk({p, "_rsp_err"}, bus.rsp_err, 0);
        chk({p, "_jobs_done"}, bus.jobs_done, 0);
    endtask

    // Engine model: result f(operands) lat cycles after start, busy held extra cycles beyond it.
    always @(posedge clk) begin
        if (rst) begin
            run               <= 1'b0;
            bus.eng_busy      <= 1'b0;
            bus.eng_valid     <= 1'b0;
            bus.eng_candidate <= '0;
        end else if (bus.eng_en) begin
            run           <= 1'b1;
            k             <= 1;
            bus.eng_busy  <= 1'b1;
            bus.eng_valid <= 1'b0;
        end else if (run) begin
            k             <= k + 1;
            bus.eng_valid <= !hang && k == lat;
            if (k == lat) bus.eng_candidate <= f(bus.eng_central, bus.eng_radius, bus.eng_mode);
            if (k == lat + extra) begin
                run          <= 1'b0;
                bus.eng_busy <= 1'b0;
            end
        end else begin
            bus.eng_valid <= 1'b0;
        end
    end

    // Monitor + scoreboard: expectations pushed at grant, popped at the response handshake.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            jobs    = 0;
            prev_rv = 0;
        end else begin
            if (bus.eng_en) begin
                ens++;
                t_en = cyc;
                chk("en_while_busy", bus.eng_busy, 0);
            end
            if (|(bus.req_valid & bus.req_ready)) begin
                chk("grant_onehot", $countones(bus.req_ready), 1);
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) gid = i;
                ops    = {bus.req_central[gid*24 +: 24], bus.req_radius[gid*12 +: 12], bus.req_mode[gid*2 +: 2]};
                e.id   = IDW'(gid);
                e.cand = hang ? 8'd0 : f(ops[37:14], ops[13:2], ops[1:0]);
                e.err  = hang;
                e.ops  = ops;
                q.push_back(e);
                last_id = gid;
                grants++;
            end
            if (bus.eng_valid) begin
                t_ev = cyc;
                if (q.size() > 0) chk("eng_ops", {bus.eng_central, bus.eng_radius, bus.eng_mode}, q[0].ops);
            end
            if (bus.rsp_valid && !prev_rv) t_rv = cyc;
            prev_rv = bus.rsp_valid;
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) begin
                    chk("rsp_unexpected", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk("rsp_id", bus.rsp_id, e.id);
                    chk("rsp_candidate", bus.rsp_candidate, e.cand);
                    chk("rsp_err", bus.rsp_err, e.err);
                    chk("jobs_done", bus.jobs_done, jobs);
                    last_cand = bus.rsp_candidate;
                    jobs++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, nerr=%0d", nerr);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid   = '0;
        bus.req_central = '0;
        bus.req_radius  = '0;
        bus.req_mode    = '0;
        bus.rsp_ready   = 1'b0;
        vecs = '{'{4'b1111, 3, 0, 0}, '{4'b1111, 1, 2, 1}, '{4'b1111, 5, 0, 2}, '{4'b1111, 2, 1, 3},
                 '{4'b1111, 4, 3, 0}, '{4'b0001, 2, 0, 0}, '{4'b1001, 3, 0, 3}, '{4'b1001, 1, 0, 0},
                 '{4'b0110, 6, 2, 1}, '{4'b0011, 2, 0, 0}, '{4'b1100, 3, 1, 2}, '{4'b0110, 1, 0, 1}};
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_checks("rst");
        @(posedge clk);
        #1 rst = 1'b0;

        // Single job from requester 2 with a long engine run.
        @(posedge clk);
        #1;
        set_job(2, 24'h553377, 12'h444, 2'd1);
        lat = LONG;
        extra = 0;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        e0 = ens;
        wait_grant("t1_grant", n);
        chk("t1_id", last_id, 2);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_done("t1_done");
        chk("t1_cand", last_cand, 17);
        chk("t1_en_pulses", ens - e0, 1);
        @(negedge clk);
        chk("t1_jobs_done", bus.jobs_done, 1);

        // Response back-pressure: everything frozen while rsp_ready is low.
        @(posedge clk);
        #1;
        set_job(1, 24'($urandom), 12'($urandom), 2'($urandom));
        lat = 5;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0010;
        wait_grant("c_grant", n);
        chk("c_id", last_id, 1);
        @(posedge clk);
        #1 bus.req_valid = 4'b1111;
        for (int i = 0; i < 100 && !bus.rsp_valid; i++) begin
            @(negedge clk);
            #1;
        end
        chk("c_rsp_valid", bus.rsp_valid, 1);
        sid = bus.rsp_id;
        scand = bus.rsp_candidate;
        serr = bus.rsp_err;
        bad = 0;
        e0 = ens;
        g0 = grants;
        repeat (50) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.rsp_id !== sid || bus.rsp_candidate !== scand || bus.rsp_err !== serr) bad++;
            if (bus.req_ready != '0) bad++;
        end
        chk("c_hold_stable", bad, 0);
        chk("c_hold_no_grant", grants - g0, 0);
        chk("c_hold_no_en", ens - e0, 0);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_grant("c_next_grant", n);
        chk("c_next_id", last_id, 2);
        chk("c_next_gap", n, 2);
        @(posedge clk);
        #1 bus.req_valid = '0;
        wait_done("c_done");

        // Drain: response waits for busy to fall after eng_valid.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            set_job(0, 24'($urandom), 12'($urandom), 2'($urandom));
            lat = 4;
            extra = dx[c];
            bus.req_valid = 4'b0001;
            wait_grant("d_grant", n);
            chk("d_id", last_id, 0);
            @(posedge clk);
            #1 bus.req_valid = '0;
            wait_done("d_done");
            chk($sformatf("d_lat_extra%0d", dx[c]), t_rv - t_ev, dexp[c]);
        end

        // Reset five cycles into RUN abandons the job.
        @(posedge clk);
        #1;
        set_job(2, 24'($urandom), 12'($urandom), 2'($urandom));
        lat = 300;
        extra = 0;
        bus.req_valid = 4'b0100;
        wait_grant("e_grant", n);
        chk("e_id", last_id, 2);
        @(posedge clk);
        #1 bus.req_valid = '0;
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        reset_checks("midrst");
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid) bad++;
        end
        chk("e_no_rsp", bad, 0);

        // Table: rr pointer starts at 0 again after the reset.
        for (int v = 0; v < 12; v++) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++) set_job(r, 24'($urandom), 12'($urandom), 2'($urandom));
            lat = vecs[v].lat;
            extra = vecs[v].extra;
            bus.rsp_ready = 1'b1;
            bus.req_valid = vecs[v].mask;
            wait_grant($sformatf("v%0d_grant", v), n);
            chk($sformatf("v%0d_id", v), last_id, vecs[v].exp_id);
            wait_done($sformatf("v%0d_done", v));
        end
        @(posedge clk);
        #1 bus.req_valid = '0;

`ifdef SET_SCHED_TIMEOUT_EN
        // Watchdog: engine never answers.
        set_job(3, 24'($urandom), 12'($urandom), 2'($urandom));
        hang = 1;
        lat = 40;
        extra = 0;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1000;
        wait_grant("g_grant", n);
        chk("g_id", last_id, 3);
        @(posedge clk);
        #1 bus.req_valid = '0;
        for (int i = 0; i < 100 && !bus.rsp_valid; i++) begin
            @(negedge clk);
            #1;
        end
        chk("g_to_lat", t_rv - t_en, 22);
        chk("g_err", bus.rsp_err, 1);
        chk("g_cand", bus.rsp_candidate, 0);
        for (int i = 0; i < 100 && bus.eng_busy; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        hang = 0;
        lat = 3;
        wait_done("g_done");
        bus.req_valid = 4'b0001;
        wait_grant("g2_grant", n);
        chk("g2_id", last_id, 0);
        @(posedge clk);
        #1 bus.req_valid = '0;
        chk("g_err_clear", bus.rsp_err, 0);
        wait_done("g2_done");
`endif

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/set_job_sched.md
Name: set_job_sched

Overview:
- Round-robin scheduler that shares one SET candidate-counting engine between NREQ requesters.
- Accepts one job (central, radius, mode) per grant and launches the engine with a one-cycle en pulse.
- Holds the job operands stable on the engine inputs for the whole run, then returns the 8-bit candidate count tagged with the requester id.
- Sits between the host-side job sources and the SET engine instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester id width; must equal clog2(NREQ), minimum 1.
- TIMEOUT_CYC, 1023, engine-run watchdog limit in cycles; used only with SET_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester job-request flag.
- req_ready  out  NREQ  one-hot grant/accept; a job transfers when req_valid[k]&req_ready[k].
- req_central  in  24*NREQ  slice k = {x1,y1,x2,y2,x3,y3}, 4 bits each.
- req_radius  in  12*NREQ  slice k = {r1,r2,r3}, 4 bits each.
- req_mode  in  2*NREQ  slice k = mode 0..3.
- eng_en  out  1  one-cycle engine start pulse.
- eng_central  out  24  latched central.
- eng_radius  out  12  latched radius.
- eng_mode  out  2  latched mode.
- eng_busy  in  1  engine busy.
- eng_valid  in  1  engine result strobe.
- eng_candidate  in  8  engine result.
- rsp_valid  out  1  result available; held until accepted.
- rsp_ready  in  1  result accept.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_candidate  out  8  candidate count.
- rsp_err  out  1  watchdog-timeout flag; tied 0 without the macro.
- jobs_done  out  16  count of completed responses, wraps at 65535 to 0.

Behaviour:
- Reset values: req_ready=0, eng_en=0, eng_central/eng_radius/eng_mode=0, rsp_valid=0, rsp_id=0, rsp_candidate=0, rsp_err=0, jobs_done=0, rr pointer=0, state=IDLE.
- Reset mid-run: abandons the job and asserts no response; the engine is reset by the same rst.
- FSM states: IDLE, LAUNCH, RUN, DRAIN, RESP.
- IDLE:
  - req_ready is combinational: one-hot of the first asserted req_valid, searching from rr pointer upward with wrap.
  - req_ready is 0 when no request is pending or state is not IDLE.
  - On transfer: latch the slice into eng_* registers and the index into rsp_id; go to LAUNCH.
- LAUNCH: eng_en=1 for exactly this cycle; go to RUN.
- RUN:
  - eng_* operands stay constant.
  - On eng_valid=1: capture eng_candidate into rsp_candidate; go to DRAIN.
  - eng_valid seen in LAUNCH is ignored.
- DRAIN: wait until eng_busy=0 (may be 0 immediately, giving a 1-cycle pass-through); go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_candidate and rsp_err are stable.
  - On rsp_ready=1: rsp_valid falls next cycle, jobs_done+1, rr pointer = rsp_id+1 mod NREQ, go to IDLE.
- Minimum latency: accept at cycle 0, eng_en at cycle 1. If eng_valid arrives at cycle t, rsp_valid rises at cycle t+2 at the earliest.
- Earliest next grant: the cycle after the rsp handshake.
- Fairness: the requester just served has lowest priority. Requests raised while the engine is busy wait; nothing is queued inside the block.
- A requester may drop req_valid before its grant without effect. Operands are sampled only in the grant cycle.
- rsp_ready asserted outside RESP is ignored.
- The block never pulses eng_en while eng_busy=1 (guaranteed by DRAIN).

Optional Feature:
- SET_SCHED_TIMEOUT_EN defined:
  - A 10-bit+ run counter clears in LAUNCH and increments in RUN.
  - On reaching TIMEOUT_CYC without eng_valid: go to RESP with rsp_candidate=0 and rsp_err=1.
  - rsp_err clears on the next grant.
- SET_SCHED_TIMEOUT_EN undefined: no counter; RUN waits indefinitely; rsp_err is constant 0.

Decomposition:
- Package set_pkg:
  - Field widths CENTRAL_W=24, RADIUS_W=12, MODE_W=2, CAND_W=8.
  - State encoding enum of the 5 states.
  - Mode constants MODE_A=0, MODE_AND=1, MODE_XOR=2, MODE_TWO_OF_THREE=3.
- One sub-module: set_rr_arb, a combinational round-robin one-hot picker with inputs req_valid and rr pointer, outputs grant and grant index.

Test Plan:
- Single job from req 2 (central=0x553377, radius=0x444, mode=1), engine model returns 8'd17 after 300 cycles -> one eng_en pulse; eng_* equal the job through RUN; rsp_valid with rsp_id=2, rsp_candidate=17; jobs_done=1.
- All 4 requesters hold req_valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; no eng_en while eng_busy=1.
- rsp_ready held 0 for 50 cycles in RESP -> rsp_* stable; no new grant or eng_en; grant follows release.
- rst asserted 5 cycles into RUN -> all outputs reset next cycle; no rsp_valid; rr pointer=0.
- Engine asserts eng_valid with eng_busy staying high 3 more cycles -> RESP entered only after busy falls; candidate is the value captured at eng_valid.
- With SET_SCHED_TIMEOUT_EN and TIMEOUT_CYC=20, engine never responds -> rsp_valid rises about 22 cycles after eng_en with rsp_err=1, rsp_candidate=0; the next job clears rsp_err.
